// File: rtl/operand_sum_pipe.sv
// Two-stage elastic adder pipe: stage 1 captures an (a, b) pair, stage 2 holds the
// full-width sum, and a wrapping counter tracks how many results have been delivered.
module operand_sum_pipe #(
    parameter int unsigned DW    = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_a,
    input  logic [DW-1:0]     in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW:0]       out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              busy
);

    localparam int unsigned SW = DW + 1;

    logic          s1_valid;
    logic [DW-1:0] s1_a;
    logic [DW-1:0] s1_b;
    logic          s2_free;
    logic          s1_free;
    logic          in_fire;
    logic          xfer;
    logic          out_fire;

    // Advance conditions; in_ready follows out_ready combinationally (no skid buffer).
    always_comb begin
        s2_free  = !out_valid || out_ready;
        s1_free  = !s1_valid || s2_free;
        in_fire  = in_valid && s1_free;
        xfer     = s1_valid && s2_free;
        out_fire = out_valid && out_ready;
    end

    assign in_ready = s1_free;
    assign busy     = s1_valid || out_valid;

    // Stage 1: operand capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_a     <= in_a;
            s1_b     <= in_b;
        end else if (xfer) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: sum register, which is also the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_sum   <= SW'(s1_a) + SW'(s1_b);
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    // Delivered-result counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count <= '0;
        end else if (out_fire) begin
            out_count <= out_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_operand_sum_pipe.sv
// Directed bench for operand_sum_pipe: reset, latency, streaming, backpressure,
// counter wrap and asynchronous mid-flight reset.
module tb_operand_sum_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_sum;
    logic [7:0] out_count;
    logic       busy;

    int checks;
    int failures;

    operand_sum_pipe #(.DW(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = 4'd0; in_b = 4'd0;
        repeat (3) step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_low got=%0b exp=1", in_ready); end
        rst_n = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_sum !== 5'd0) begin failures++; $display("FAIL reset_out_sum got=%0d exp=0", out_sum); end
        checks++; if (out_count !== 8'd0) begin failures++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 4'd1; in_b = 4'd2;
        step();
        in_valid = 1'b0; in_a = 4'd15; in_b = 4'd15;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%0b exp=0", out_valid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%0b exp=1", busy); end
        step();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", out_valid); end
        checks++; if (out_sum !== 5'd3) begin failures++; $display("FAIL single_sum got=%0d exp=3", out_sum); end
        checks++; if (out_count !== 8'd0) begin failures++; $display("FAIL single_count_before got=%0d exp=0", out_count); end
        step();
        checks++; if (out_count !== 8'd1) begin failures++; $display("FAIL single_count_after got=%0d exp=1", out_count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_no_dup got=%0b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 4'd3; in_b = 4'd4;
        step();
        in_a = 4'd7; in_b = 4'd8;
        step();
        checks++; if (out_valid !== 1'b1 || out_sum !== 5'd7) begin failures++; $display("FAIL stream_sum0 got=%0d/%0b exp=7/1", out_sum, out_valid); end
        in_a = 4'd15; in_b = 4'd15;
        step();
        checks++; if (out_valid !== 1'b1 || out_sum !== 5'd15) begin failures++; $display("FAIL stream_sum1 got=%0d/%0b exp=15/1", out_sum, out_valid); end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || out_sum !== 5'b11110) begin failures++; $display("FAIL stream_sum_max got=%0d/%0b exp=30/1", out_sum, out_valid); end
        step();
        // one delivery from the single-transfer test plus three here
        checks++; if (out_count !== 8'd4) begin failures++; $display("FAIL stream_count got=%0d exp=4", out_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stream_idle got=%0b exp=0", busy); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 4'd5; in_b = 4'd6;
        step();
        in_a = 4'd1; in_b = 4'd1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_fill_s1 got=%0b exp=1", in_ready); end
        step();
        in_a = 4'd2; in_b = 4'd2;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%0b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_sum !== 5'd11) begin failures++; $display("FAIL bp_first got=%0d/%0b exp=11/1", out_sum, out_valid); end
        repeat (2) step();
        checks++; if (out_sum !== 5'd11 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold got=%0d/%0b exp=11/0", out_sum, in_ready); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_sum !== 5'd2) begin failures++; $display("FAIL bp_second got=%0d/%0b exp=2/1", out_sum, out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || out_sum !== 5'd4) begin failures++; $display("FAIL bp_third got=%0d/%0b exp=4/1", out_sum, out_valid); end
        step();
        checks++; if (out_count !== 8'd7 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_count got=%0d/%0b exp=7/0", out_count, out_valid); end
    endtask

    task automatic test_wrap();
        logic [4:0] exp_last;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 249; i++) begin
            in_a = 4'(i);
            in_b = 4'(i * 3);
            step();
        end
        in_valid = 1'b0;
        exp_last = 5'(4'(248)) + 5'(4'(248 * 3));
        step();
        checks++; if (out_sum !== exp_last || out_count !== 8'd255) begin failures++; $display("FAIL wrap_pre got=%0d/%0d exp=%0d/255", out_sum, out_count, exp_last); end
        step();
        checks++; if (out_count !== 8'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", out_count); end
        in_valid = 1'b1; in_a = 4'd6; in_b = 4'd7;
        step();
        in_valid = 1'b0;
        step();
        checks++; if (out_sum !== 5'd13 || out_count !== 8'd0) begin failures++; $display("FAIL wrap_next_sum got=%0d/%0d exp=13/0", out_sum, out_count); end
        step();
        checks++; if (out_count !== 8'd1) begin failures++; $display("FAIL wrap_continue got=%0d exp=1", out_count); end
    endtask

    task automatic test_midflight_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 4'd4; in_b = 4'd4;
        step();
        in_a = 4'd3; in_b = 4'd3;
        step();
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL mid_full got=%0b/%0b/%0b exp=1/1/0", busy, out_valid, in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_async_drop got=%0b/%0b exp=0/0", out_valid, busy); end
        checks++; if (out_count !== 8'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL mid_async_count got=%0d/%0b exp=0/1", out_count, in_ready); end
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 4'd9; in_b = 4'd9;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_early got=%0b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || out_sum !== 5'd18) begin failures++; $display("FAIL mid_restart got=%0d/%0b exp=18/1", out_sum, out_valid); end
        step();
        checks++; if (out_count !== 8'd1) begin failures++; $display("FAIL mid_count got=%0d exp=1", out_count); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_midflight_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
